// File: rtl/maxpool_2x2_sched.sv
// maxpool_2x2_sched
//   Schedules 2x2 / stride-2 max pooling with a folded ReLU over a conv feature
//   map streamed row-major, one pixel per beat. Even rows are parked in a
//   one-row line buffer. On odd rows each 2x2 window is closed on its odd
//   column, and max(a, b, c, d, 0) is emitted as one registered pooled pixel.
//
// Parameters
//   DATA_W  pixel width, signed two's complement
//   IMG_W   input map width  (even, >= 2)
//   IMG_H   input map height (even, >= 2)
//
// Ports
//   clk, rst_n          clock / asynchronous active-low reset
//   start               1-cycle frame start pulse (ignored while busy)
//   busy                frame in progress
//   done                1-cycle pulse once the final pooled pixel is taken
//   in_data/valid/ready input pixel stream
//   out_data/valid/ready/last
//                       pooled pixel stream; last marks the final window

module maxpool_2x2_sched #(
  parameter int DATA_W = 18,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = (IMG_H / 2 > 1) ? $clog2(IMG_H / 2) : 1;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    POOL,
    DRAIN
  } state_t;

  state_t state;

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] rowpair;

  logic [DATA_W-1:0] lbuf [IMG_W];
  logic [DATA_W-1:0] hold_c;

  logic in_fire;
  logic out_fire;
  logic last_col;
  logic last_rowpair;
  logic pool_fire;

  logic [COL_W-1:0]         col_even;
  logic signed [DATA_W-1:0] win_a;
  logic signed [DATA_W-1:0] win_b;
  logic signed [DATA_W-1:0] win_c;
  logic signed [DATA_W-1:0] win_d;
  logic signed [DATA_W-1:0] max_ab;
  logic signed [DATA_W-1:0] max_cd;
  logic signed [DATA_W-1:0] max_all;
  logic [DATA_W-1:0]        pooled;

  // POOL stalls input only while a result is parked and downstream is not taking it,
  // so a new result can overwrite the register on the same edge it is consumed.
  always_comb begin
    in_ready = 1'b0;
    case (state)
      FILL:    in_ready = 1'b1;
      POOL:    in_ready = !out_valid || out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  assign in_fire      = in_valid && in_ready;
  assign out_fire     = out_valid && out_ready;
  assign last_col     = (col == COL_W'(IMG_W - 1));
  assign last_rowpair = (rowpair == ROW_W'(IMG_H / 2 - 1));
  assign pool_fire    = (state == POOL) && in_fire && col[0];

  // Window: a, b from the buffered even row; c held from the even column of
  // the odd row; d is the pixel arriving now.
  assign col_even = col & ~COL_W'(1);
  assign win_a    = $signed(lbuf[col_even]);
  assign win_b    = $signed(lbuf[col]);
  assign win_c    = $signed(hold_c);
  assign win_d    = $signed(in_data);

  assign max_ab  = (win_a > win_b) ? win_a : win_b;
  assign max_cd  = (win_c > win_d) ? win_c : win_d;
  assign max_all = (max_ab > max_cd) ? max_ab : max_cd;
  assign pooled  = max_all[DATA_W-1] ? '0 : max_all;

  // Line buffer carries no reset; it is fully rewritten by every FILL row.
  always_ff @(posedge clk) begin
    if (state == FILL && in_fire) begin
      lbuf[col] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      col       <= '0;
      rowpair   <= '0;
      hold_c    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      done <= 1'b0;

      if (out_fire) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      if (pool_fire) begin
        out_valid <= 1'b1;
        out_data  <= pooled;
        out_last  <= last_col && last_rowpair;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state   <= FILL;
            col     <= '0;
            rowpair <= '0;
            busy    <= 1'b1;
          end
        end

        FILL: begin
          if (in_fire) begin
            if (last_col) begin
              col   <= '0;
              state <= POOL;
            end else begin
              col <= col + 1'b1;
            end
          end
        end

        POOL: begin
          if (in_fire) begin
            if (!col[0]) begin
              hold_c <= in_data;
            end
            if (last_col) begin
              col <= '0;
              if (last_rowpair) begin
                state <= DRAIN;
              end else begin
                rowpair <= rowpair + 1'b1;
                state   <= FILL;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end

        DRAIN: begin
          if (!out_valid || out_fire) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maxpool_2x2_sched.sv
// Bench for maxpool_2x2_sched: a 4x4 instance (index 0) for directed cases and
// a 28x28 instance (index 1) for a randomized full frame. Expected pooled
// pixels come from plain 2x2 max/ReLU arithmetic over each generated frame and
// are queued at frame issue; per-instance monitors pop and compare on output
// transfers.

module tb_maxpool_2x2_sched;

  localparam int DW = 18;

  logic          clk;
  logic          rst_n     [2];
  logic          start     [2];
  logic          busy      [2];
  logic          done      [2];
  logic [DW-1:0] in_data   [2];
  logic          in_valid  [2];
  logic          in_ready  [2];
  logic [DW-1:0] out_data  [2];
  logic          out_valid [2];
  logic          out_ready [2];
  logic          out_last  [2];

  logic stall   [2];
  logic rnd_rdy [2];

  int checks = 0;
  int errors = 0;
  int n_done [2];
  int n_last [2];
  int n_out  [2];

  logic [DW:0] exp_q0 [$];
  logic [DW:0] exp_q1 [$];

  maxpool_2x2_sched #(.DATA_W(DW), .IMG_W(4), .IMG_H(4)) u_small (
    .clk(clk), .rst_n(rst_n[0]), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_last(out_last[0])
  );

  maxpool_2x2_sched #(.DATA_W(DW), .IMG_W(28), .IMG_H(28)) u_big (
    .clk(clk), .rst_n(rst_n[1]), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_last(out_last[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int img_w(input int d);
    return (d == 0) ? 4 : 28;
  endfunction

  function automatic int img_h(input int d);
    return (d == 0) ? 4 : 28;
  endfunction

  task automatic chk(input string name, input int d, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at %0t", name, d, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int d, input logic [DW:0] v);
    if (d == 0) exp_q0.push_back(v);
    else        exp_q1.push_back(v);
  endtask

  function automatic int exp_size(input int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  task automatic flush_exp(input int d);
    if (d == 0) exp_q0.delete();
    else        exp_q1.delete();
  endtask

  task automatic pop_exp(input int d, output logic [DW:0] v);
    if (d == 0) v = exp_q0.pop_front();
    else        v = exp_q1.pop_front();
  endtask

  // Reference: each 2x2 window's max over signed pixel values, floored at 0.
  task automatic push_model(input int d, input int pix[$]);
    int w;
    int h;
    int m;
    int vals[4];
    logic lst;
    w = img_w(d);
    h = img_h(d);
    for (int r = 0; r < h / 2; r++) begin
      for (int c = 0; c < w / 2; c++) begin
        vals[0] = pix[(2 * r) * w + 2 * c];
        vals[1] = pix[(2 * r) * w + 2 * c + 1];
        vals[2] = pix[(2 * r + 1) * w + 2 * c];
        vals[3] = pix[(2 * r + 1) * w + 2 * c + 1];
        m = 0;
        foreach (vals[k]) if (vals[k] > m) m = vals[k];
        lst = (r == h / 2 - 1) && (c == w / 2 - 1);
        push_exp(d, {lst, DW'(m)});
      end
    end
  endtask

  function automatic int rand_pix();
    logic [DW-1:0] r;
    r = DW'($urandom);
    return int'($signed(r));
  endfunction

  task automatic monitor(input int d);
    logic          exp_done;
    logic          held_v;
    logic [DW-1:0] held;
    logic [DW:0]   e;
    exp_done = 1'b0;
    held_v   = 1'b0;
    held     = '0;
    forever begin
      @(negedge clk);
      if (!rst_n[d]) begin
        exp_done = 1'b0;
        held_v   = 1'b0;
        continue;
      end
      chk("done_timing", d, 32'(done[d]), 32'(exp_done));
      if (done[d]) n_done[d]++;
      exp_done = 1'b0;
      if (held_v) begin
        chk("valid_held", d, 32'(out_valid[d]), 32'd1);
        chk("data_held", d, 32'(out_data[d]), 32'(held));
      end
      held_v = 1'b0;
      if (out_valid[d]) begin
        if (out_ready[d]) begin
          n_out[d]++;
          if (out_last[d]) n_last[d]++;
          if (exp_size(d) == 0) begin
            chk("unexpected_output", d, 32'(out_data[d]), 32'hFFFF_FFFF);
          end else begin
            pop_exp(d, e);
            chk("out_data", d, 32'(out_data[d]), 32'(e[DW-1:0]));
            chk("out_last", d, 32'(out_last[d]), 32'(e[DW]));
            exp_done = e[DW];
          end
        end else begin
          held_v = 1'b1;
          held   = out_data[d];
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        if (stall[d])        out_ready[d] = 1'b0;
        else if (rnd_rdy[d]) out_ready[d] = 1'($urandom_range(0, 1));
        else                 out_ready[d] = 1'b1;
      end
    end
  end

  task automatic begin_frame(input int d, input int pix[$]);
    push_model(d, pix);
    start[d] = 1'b1;
    @(posedge clk);
    #1;
    start[d] = 1'b0;
    chk("busy_after_start", d, 32'(busy[d]), 32'd1);
  endtask

  task automatic send_pixels(input int d, input int pix[$], input int first,
                             input int n, input bit gaps);
    int t;
    for (int i = first; i < first + n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      in_data[d]  = DW'(pix[i]);
      in_valid[d] = 1'b1;
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!in_ready[d] && t < 400);
      if (!in_ready[d]) begin
        chk("in_ready_timeout", d, 32'(in_ready[d]), 32'd1);
        in_valid[d] = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      in_valid[d] = 1'b0;
    end
  endtask

  task automatic finish_frame(input int d, input int nd0, input int nl0, input int no0);
    int t;
    t = 0;
    while (n_done[d] == nd0 && t < 6000) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk("done_count", d, 32'(n_done[d] - nd0), 32'd1);
    chk("last_count", d, 32'(n_last[d] - nl0), 32'd1);
    chk("out_count", d, 32'(n_out[d] - no0), 32'(img_w(d) * img_h(d) / 4));
    chk("queue_empty", d, 32'(exp_size(d)), 32'd0);
    chk("busy_after_done", d, 32'(busy[d]), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int d, input int pix[$], input bit gaps);
    int nd0;
    int nl0;
    int no0;
    nd0 = n_done[d];
    nl0 = n_last[d];
    no0 = n_out[d];
    begin_frame(d, pix);
    send_pixels(d, pix, 0, pix.size(), gaps);
    finish_frame(d, nd0, nl0, no0);
  endtask

  task automatic check_quiet(input int d, input string tag);
    chk({tag, "_busy"}, d, 32'(busy[d]), 32'd0);
    chk({tag, "_done"}, d, 32'(done[d]), 32'd0);
    chk({tag, "_in_ready"}, d, 32'(in_ready[d]), 32'd0);
    chk({tag, "_out_valid"}, d, 32'(out_valid[d]), 32'd0);
    chk({tag, "_out_data"}, d, 32'(out_data[d]), 32'd0);
    chk({tag, "_out_last"}, d, 32'(out_last[d]), 32'd0);
  endtask

  initial begin
    int pix[$];
    int nd0;
    int nl0;
    int no0;
    logic [DW-1:0] held;
    int t;

    for (int d = 0; d < 2; d++) begin
      rst_n[d]     = 1'b0;
      start[d]     = 1'b0;
      in_valid[d]  = 1'b0;
      in_data[d]   = '0;
      stall[d]     = 1'b0;
      rnd_rdy[d]   = 1'b0;
      out_ready[d] = 1'b1;
      n_done[d]    = 0;
      n_last[d]    = 0;
      n_out[d]     = 0;
    end

    #12;
    check_quiet(0, "reset");
    check_quiet(1, "reset");
    @(posedge clk);
    #1;
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(posedge clk);
    #1;
    check_quiet(0, "idle");

    // Ramp 1..16: pooled 6, 8, 14, 16.
    pix.delete();
    for (int i = 1; i <= 16; i++) pix.push_back(i);
    run_frame(0, pix, 1'b0);

    // All-negative window -> 0; window with extremes -> 0x1FFFF.
    pix.delete();
    pix = '{-5, -3, -1, 131071, -1, -7, -131072, 3,
            rand_pix(), rand_pix(), rand_pix(), rand_pix(),
            rand_pix(), rand_pix(), rand_pix(), rand_pix()};
    run_frame(0, pix, 1'b0);

    // Output held off for several cycles while a result is parked in POOL.
    pix.delete();
    for (int i = 0; i < 16; i++) pix.push_back(rand_pix());
    nd0 = n_done[0];
    nl0 = n_last[0];
    no0 = n_out[0];
    stall[0]     = 1'b1;
    out_ready[0] = 1'b0;
    begin_frame(0, pix);
    fork
      send_pixels(0, pix, 0, 16, 1'b0);
      begin
        t = 0;
        do begin
          @(negedge clk);
          t++;
        end while (!out_valid[0] && t < 200);
        chk("stall_valid_seen", 0, 32'(out_valid[0]), 32'd1);
        held = out_data[0];
        repeat (6) begin
          @(negedge clk);
          chk("stall_in_ready", 0, 32'(in_ready[0]), 32'd0);
          chk("stall_out_valid", 0, 32'(out_valid[0]), 32'd1);
          chk("stall_out_data", 0, 32'(out_data[0]), 32'(held));
        end
        stall[0] = 1'b0;
      end
    join
    finish_frame(0, nd0, nl0, no0);

    // Reset in the middle of the first POOL row, then a clean frame.
    pix.delete();
    for (int i = 0; i < 16; i++) pix.push_back(rand_pix());
    nd0 = n_done[0];
    begin_frame(0, pix);
    send_pixels(0, pix, 0, 6, 1'b0);
    #1;
    rst_n[0] = 1'b0;
    #1;
    check_quiet(0, "midreset");
    @(posedge clk);
    #1;
    flush_exp(0);
    rst_n[0] = 1'b1;
    chk("no_done_on_abort", 0, 32'(n_done[0] - nd0), 32'd0);
    rnd_rdy[0] = 1'b1;
    pix.delete();
    for (int i = 0; i < 16; i++) pix.push_back(rand_pix());
    run_frame(0, pix, 1'b1);

    // Full 28x28 frame: random gaps, random out_ready, stray start mid-frame.
    rnd_rdy[1] = 1'b1;
    pix.delete();
    for (int i = 0; i < 28 * 28; i++) pix.push_back(rand_pix());
    nd0 = n_done[1];
    nl0 = n_last[1];
    no0 = n_out[1];
    begin_frame(1, pix);
    fork
      send_pixels(1, pix, 0, 28 * 28, 1'b1);
      begin
        repeat (60) @(posedge clk);
        #1;
        start[1] = 1'b1;
        @(posedge clk);
        #1;
        start[1] = 1'b0;
      end
    join
    finish_frame(1, nd0, nl0, no0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
